// File: rtl/chunked_addsub_if.sv
// Handshake and data bundle for chunked_addsub: operand side (in_*),
// result side (out_*, sum, flags). The master drives operands and accepts
// results; the slave is the adder/subtractor itself.
`timescale 1ns/1ps
interface chunked_addsub_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic             overflow;
    logic             zero;

    modport master (
        output in_valid, in1, in2, sub, out_ready,
        input  in_ready, out_valid, sum, carry, overflow, zero
    );

    modport slave (
        input  in_valid, in1, in2, sub, out_ready,
        output in_ready, out_valid, sum, carry, overflow, zero
    );
endinterface

// File: rtl/chunked_addsub.sv
// Multi-cycle adder/subtractor. Adds CHUNK bits per clock with a registered
// ripple carry between chunks, so the critical path is one CHUNK-bit adder.
// Subtraction is A + ~B + 1: B is inverted at accept time and the carry-in is
// seeded with 1. Carry, signed overflow and zero flags are registered with the
// final chunk and held, together with sum, until the next operation starts.
`timescale 1ns/1ps
module chunked_addsub #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    chunked_addsub_if.slave bus
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT   = CNT_W'(NCHUNK - 1);
    localparam logic [WIDTH-1:0] CHUNK_MASK = WIDTH'({CHUNK{1'b1}});

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;       // already inverted for subtraction
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cy_q, cy_d;     // running inter-chunk carry
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;

    logic [31:0]      shamt_s;
    logic [CHUNK-1:0] a_chunk_s;
    logic [CHUNK-1:0] b_chunk_s;
    logic [CHUNK:0]   chunk_res_s;
    logic [WIDTH-1:0] merged_sum_s;

    // Current chunk slice, its CHUNK-bit add, and the sum with that chunk merged in.
    always_comb begin
        shamt_s      = 32'(cnt_q) * 32'(CHUNK);
        a_chunk_s    = CHUNK'(a_q >> shamt_s);
        b_chunk_s    = CHUNK'(b_q >> shamt_s);
        chunk_res_s  = {1'b0, a_chunk_s} + {1'b0, b_chunk_s} + {{CHUNK{1'b0}}, cy_q};
        merged_sum_s = (sum_q & ~(CHUNK_MASK << shamt_s))
                     | (WIDTH'(chunk_res_s[CHUNK-1:0]) << shamt_s);
    end

    // Next-state and datapath update for the IDLE -> CALC -> DONE sequence.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        cy_d    = cy_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;
        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.in1;
                    b_d     = bus.sub ? ~bus.in2 : bus.in2;
                    cy_d    = bus.sub;
                    cnt_d   = '0;
                    state_d = S_CALC;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CALC: begin
                sum_d = merged_sum_s;
                cy_d  = chunk_res_s[CHUNK];
                if (cnt_q == LAST_CNT) begin
                    cnt_d   = '0;
                    carry_d = chunk_res_s[CHUNK];
                    ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1])
                            & (merged_sum_s[WIDTH-1] != a_q[WIDTH-1]);
                    zero_d  = (merged_sum_s == '0);
                    state_d = S_DONE;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any in-flight operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            cy_q    <= 1'b0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            cy_q    <= cy_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
        end
    end

    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.sum       = sum_q;
    assign bus.carry     = carry_q;
    assign bus.overflow  = ovf_q;
    assign bus.zero      = zero_q;
endmodule

// File: tb/tb_chunked_addsub.sv
// Directed bench for chunked_addsub: 32/8, 32/32 and 16/4 instances.
`timescale 1ns/1ps
module tb_chunked_addsub;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    int   lat;

    always #5 clk = ~clk;

    chunked_addsub_if #(.WIDTH(32)) if0 ();
    chunked_addsub_if #(.WIDTH(32)) if1 ();
    chunked_addsub_if #(.WIDTH(16)) if2 ();

    chunked_addsub #(.WIDTH(32), .CHUNK(8))  dut0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
    chunked_addsub #(.WIDTH(32), .CHUNK(32)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
    chunked_addsub #(.WIDTH(16), .CHUNK(4))  dut2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave));

    task automatic init_inputs();
        if0.in_valid = 1'b0; if0.in1 = 32'd0; if0.in2 = 32'd0; if0.sub = 1'b0; if0.out_ready = 1'b1;
        if1.in_valid = 1'b0; if1.in1 = 32'd0; if1.in2 = 32'd0; if1.sub = 1'b0; if1.out_ready = 1'b1;
        if2.in_valid = 1'b0; if2.in1 = 16'd0; if2.in2 = 16'd0; if2.sub = 1'b0; if2.out_ready = 1'b1;
    endtask

    // Present one operation to instance 0; return cycles from accept to out_valid.
    // Returns at a falling edge with out_valid high (or after the cycle budget).
    task automatic do_op0(input logic [31:0] a, input logic [31:0] b, input logic s, output int l);
        @(negedge clk);
        if0.in1 = a; if0.in2 = b; if0.sub = s; if0.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if0.in_valid = 1'b0;
        l = 0;
        while (!if0.out_valid && l < 20) begin
            @(posedge clk);
            @(negedge clk);
            l++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #23;
        checks++; if (if0.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", if0.in_ready); end
        checks++; if (if0.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", if0.out_valid); end
        checks++; if (if0.sum !== 32'd0) begin errors++; $display("FAIL reset_sum: got %h expected 0", if0.sum); end
        checks++; if ({if0.carry, if0.overflow, if0.zero} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b expected 000", {if0.carry, if0.overflow, if0.zero}); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_add_basic();
        if0.out_ready = 1'b1;
        checks++; if (if0.in_ready !== 1'b1) begin errors++; $display("FAIL basic_ready_before: got %b expected 1", if0.in_ready); end
        do_op0(32'd5, 32'd7, 1'b0, lat);
        checks++; if (lat !== 4) begin errors++; $display("FAIL basic_latency: got %0d expected 4", lat); end
        checks++; if (if0.sum !== 32'd12) begin errors++; $display("FAIL basic_sum: got %h expected c", if0.sum); end
        checks++; if ({if0.carry, if0.overflow, if0.zero} !== 3'b000) begin errors++; $display("FAIL basic_flags: got %b expected 000", {if0.carry, if0.overflow, if0.zero}); end
        checks++; if (if0.in_ready !== 1'b0) begin errors++; $display("FAIL basic_ready_done: got %b expected 0", if0.in_ready); end
        @(posedge clk);
        @(negedge clk);
        checks++; if (if0.out_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_one_cycle: got %b expected 0", if0.out_valid); end
        checks++; if (if0.in_ready !== 1'b1) begin errors++; $display("FAIL basic_ready_after: got %b expected 1", if0.in_ready); end
    endtask

    task automatic test_add_edges();
        do_op0(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, lat);
        checks++; if (if0.sum !== 32'h0000_0000) begin errors++; $display("FAIL wrap_sum: got %h expected 00000000", if0.sum); end
        checks++; if ({if0.carry, if0.overflow, if0.zero} !== 3'b101) begin errors++; $display("FAIL wrap_flags cvz: got %b expected 101", {if0.carry, if0.overflow, if0.zero}); end
        do_op0(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, lat);
        checks++; if (if0.sum !== 32'h8000_0000) begin errors++; $display("FAIL ovf_add_sum: got %h expected 80000000", if0.sum); end
        checks++; if ({if0.carry, if0.overflow, if0.zero} !== 3'b010) begin errors++; $display("FAIL ovf_add_flags cvz: got %b expected 010", {if0.carry, if0.overflow, if0.zero}); end
    endtask

    task automatic test_sub();
        do_op0(32'd3, 32'd5, 1'b1, lat);
        checks++; if (if0.sum !== 32'hFFFF_FFFE) begin errors++; $display("FAIL sub_3_5_sum: got %h expected fffffffe", if0.sum); end
        checks++; if ({if0.carry, if0.overflow, if0.zero} !== 3'b000) begin errors++; $display("FAIL sub_3_5_flags cvz: got %b expected 000", {if0.carry, if0.overflow, if0.zero}); end
        do_op0(32'd5, 32'd5, 1'b1, lat);
        checks++; if (if0.sum !== 32'd0) begin errors++; $display("FAIL sub_5_5_sum: got %h expected 0", if0.sum); end
        checks++; if ({if0.carry, if0.overflow, if0.zero} !== 3'b101) begin errors++; $display("FAIL sub_5_5_flags cvz: got %b expected 101", {if0.carry, if0.overflow, if0.zero}); end
        do_op0(32'h8000_0000, 32'd1, 1'b1, lat);
        checks++; if (if0.sum !== 32'h7FFF_FFFF) begin errors++; $display("FAIL sub_min_sum: got %h expected 7fffffff", if0.sum); end
        checks++; if ({if0.carry, if0.overflow, if0.zero} !== 3'b110) begin errors++; $display("FAIL sub_min_flags cvz: got %b expected 110", {if0.carry, if0.overflow, if0.zero}); end
    endtask

    task automatic test_back_to_back();
        int cyc;
        int first;
        int second;
        cyc = 0; first = -1; second = -1;
        @(negedge clk);
        if0.in1 = 32'd10; if0.in2 = 32'd20; if0.sub = 1'b0; if0.in_valid = 1'b1; if0.out_ready = 1'b1;
        while (second < 0 && cyc < 40) begin
            @(posedge clk);
            @(negedge clk);
            cyc++;
            if (if0.out_valid) begin
                if (first < 0) first = cyc;
                else second = cyc;
            end
        end
        if0.in_valid = 1'b0;
        checks++; if (second - first !== 6) begin errors++; $display("FAIL b2b_period: got %0d expected 6", second - first); end
        checks++; if (if0.sum !== 32'd30) begin errors++; $display("FAIL b2b_sum: got %h expected 1e", if0.sum); end
        repeat (8) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        if0.out_ready = 1'b0;
        do_op0(32'h0000_0100, 32'h0000_0200, 1'b0, lat);
        checks++; if (lat !== 4) begin errors++; $display("FAIL bp_latency: got %0d expected 4", lat); end
        for (int i = 0; i < 3; i++) begin
            if0.in1 = 32'hAAAA_0000; if0.in2 = 32'h0000_5555; if0.in_valid = 1'b1;
            @(posedge clk);
            @(negedge clk);
            checks++; if (if0.out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid[%0d]: got %b expected 1", i, if0.out_valid); end
            checks++; if (if0.in_ready !== 1'b0) begin errors++; $display("FAIL bp_hold_ready[%0d]: got %b expected 0", i, if0.in_ready); end
            checks++; if (if0.sum !== 32'h0000_0300) begin errors++; $display("FAIL bp_hold_sum[%0d]: got %h expected 300", i, if0.sum); end
            checks++; if ({if0.carry, if0.overflow, if0.zero} !== 3'b000) begin errors++; $display("FAIL bp_hold_flags[%0d]: got %b expected 000", i, {if0.carry, if0.overflow, if0.zero}); end
        end
        if0.in_valid = 1'b0;
        if0.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++; if (if0.out_valid !== 1'b0) begin errors++; $display("FAIL bp_consumed: got %b expected 0", if0.out_valid); end
        checks++; if (if0.in_ready !== 1'b1) begin errors++; $display("FAIL bp_idle_ready: got %b expected 1", if0.in_ready); end
        checks++; if (if0.sum !== 32'h0000_0300) begin errors++; $display("FAIL bp_idle_keep_sum: got %h expected 300", if0.sum); end
        repeat (6) @(posedge clk);
        @(negedge clk);
        checks++; if (if0.out_valid !== 1'b0 || if0.in_ready !== 1'b1) begin errors++; $display("FAIL bp_no_accept: got valid=%b ready=%b expected valid=0 ready=1", if0.out_valid, if0.in_ready); end
    endtask

    task automatic test_reset_abort();
        @(negedge clk);
        if0.in1 = 32'hFFFF_FFFF; if0.in2 = 32'hFFFF_FFFF; if0.sub = 1'b0; if0.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if0.in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (if0.in_ready !== 1'b1) begin errors++; $display("FAIL abort_in_ready: got %b expected 1", if0.in_ready); end
        checks++; if (if0.out_valid !== 1'b0) begin errors++; $display("FAIL abort_out_valid: got %b expected 0", if0.out_valid); end
        checks++; if (if0.sum !== 32'd0) begin errors++; $display("FAIL abort_sum: got %h expected 0", if0.sum); end
        checks++; if ({if0.carry, if0.overflow, if0.zero} !== 3'b000) begin errors++; $display("FAIL abort_flags: got %b expected 000", {if0.carry, if0.overflow, if0.zero}); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (if0.in_ready !== 1'b1) begin errors++; $display("FAIL abort_ready_after: got %b expected 1", if0.in_ready); end
        do_op0(32'd1, 32'd1, 1'b0, lat);
        checks++; if (lat !== 4) begin errors++; $display("FAIL abort_new_latency: got %0d expected 4", lat); end
        checks++; if (if0.sum !== 32'd2) begin errors++; $display("FAIL abort_new_sum: got %h expected 2", if0.sum); end
    endtask

    task automatic test_full_chunk();
        @(negedge clk);
        checks++; if (if1.in_ready !== 1'b1) begin errors++; $display("FAIL full_ready: got %b expected 1", if1.in_ready); end
        if1.in1 = 32'h1234_5678; if1.in2 = 32'h1111_1111; if1.sub = 1'b0; if1.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if1.in_valid = 1'b0;
        lat = 0;
        while (!if1.out_valid && lat < 20) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        checks++; if (lat !== 1) begin errors++; $display("FAIL full_latency: got %0d expected 1", lat); end
        checks++; if (if1.sum !== 32'h2345_6789) begin errors++; $display("FAIL full_sum: got %h expected 23456789", if1.sum); end
        checks++; if ({if1.carry, if1.overflow, if1.zero} !== 3'b000) begin errors++; $display("FAIL full_flags: got %b expected 000", {if1.carry, if1.overflow, if1.zero}); end
    endtask

    task automatic test_narrow();
        @(negedge clk);
        if2.in1 = 16'hFFFF; if2.in2 = 16'h0001; if2.sub = 1'b0; if2.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if2.in_valid = 1'b0;
        lat = 0;
        while (!if2.out_valid && lat < 20) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        checks++; if (lat !== 4) begin errors++; $display("FAIL narrow_latency: got %0d expected 4", lat); end
        checks++; if (if2.sum !== 16'h0000) begin errors++; $display("FAIL narrow_sum: got %h expected 0000", if2.sum); end
        checks++; if ({if2.carry, if2.overflow, if2.zero} !== 3'b101) begin errors++; $display("FAIL narrow_flags cvz: got %b expected 101", {if2.carry, if2.overflow, if2.zero}); end
    endtask

    initial begin
        init_inputs();
        test_reset();
        test_add_basic();
        test_add_edges();
        test_sub();
        test_back_to_back();
        test_backpressure();
        test_reset_abort();
        test_full_chunk();
        test_narrow();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
